// File: rtl/dmux_pkg.sv
// dmux_pkg: shared constants and helpers for the dmux_stream demultiplexer.
// Holds the drop counter width/saturation value and the select range check.
package dmux_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  // True when sel addresses an existing channel of an n-channel demux.
  function automatic logic idx_valid(input int sel, input int n);
    return sel < n;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// dmux_slot: one-entry output holding register with full flag.
// Ports: load/din fill the slot, ready drains it, valid/dout present it.
module dmux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain so drain+refill in one cycle keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-N valid/ready demultiplexer with broadcast.
// Ports: in_* stream, out_* per-channel streams, err/drop_cnt/clr_err status.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               err,
  output logic [CNT_W-1:0]   drop_cnt,
  input  logic               clr_err
);

  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic             sel_ok;
  logic             sel_free;
  logic             accept;
  logic             drop;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign free = ~out_valid | out_ready;

  // Decoded by compare rather than indexing so out-of-range selects
  // never read past the channel vector.
  always_comb begin
    sel_ok   = idx_valid(32'(in_sel), N);
    sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) sel_free = free[k];
    end
  end

  // Out-of-range selects are always sunk so they cannot stall the input.
  always_comb begin
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[g]),
      .ready (out_ready[g]),
      .din   (in_data),
      .valid (out_valid[g]),
      .dout  (out_data[g*WIDTH +: WIDTH])
    );
  end

  // Clear has priority over a coincident drop.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (clr_err) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (drop) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err      = err_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: scoreboard bench for dmux_stream, N=8 and N=5 instances.
// Driver pushes expected payloads per channel; negedge monitor pops/compares.
module tb_dmux_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // N=8 instance
  logic         iv8 = 0, ib8 = 0, clr8 = 0;
  logic [2:0]   is8 = 0;
  logic [15:0]  id8 = 0;
  logic [7:0]   or8 = 8'hFF;
  logic         in_ready8, err8;
  logic [7:0]   ov8, drop8;
  logic [127:0] od8;

  // N=5 instance
  logic         iv5 = 0, ib5 = 0, clr5 = 0;
  logic [2:0]   is5 = 0;
  logic [15:0]  id5 = 0;
  logic [4:0]   or5 = 5'h1F;
  logic         in_ready5, err5;
  logic [4:0]   ov5;
  logic [7:0]   drop5;
  logic [79:0]  od5;

  logic [15:0] q8 [8][$];
  logic [15:0] q5 [5][$];

  dmux_stream #(.WIDTH(16), .N(8)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(in_ready8), .in_data(id8),
    .in_sel(is8), .in_bcast(ib8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8),
    .err(err8), .drop_cnt(drop8), .clr_err(clr8)
  );

  dmux_stream #(.WIDTH(16), .N(5)) u5 (
    .clk(clk), .reset(reset),
    .in_valid(iv5), .in_ready(in_ready5), .in_data(id5),
    .in_sel(is5), .in_bcast(ib5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5),
    .err(err5), .drop_cnt(drop5), .clr_err(clr5)
  );

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic send8(input logic v, input logic [2:0] s,
                       input logic b, input logic [15:0] d,
                       input logic [7:0] r, input logic er);
    iv8 = v; is8 = s; ib8 = b; id8 = d; or8 = r;
    #2;
    if (v) begin
      chk("in_ready8", 128'(in_ready8), 128'(er));
      if (in_ready8) begin
        if (b) for (int k = 0; k < 8; k++) q8[k].push_back(d);
        else q8[s].push_back(d);
      end
    end
    @(posedge clk); #1;
    iv8 = 0; ib8 = 0;
  endtask

  task automatic send5(input logic v, input logic [2:0] s,
                       input logic [15:0] d, input logic er);
    iv5 = v; is5 = s; id5 = d;
    #2;
    if (v) begin
      chk("in_ready5", 128'(in_ready5), 128'(er));
      if (in_ready5 && s < 3'd5) q5[s].push_back(d);
    end
    @(posedge clk); #1;
    iv5 = 0;
  endtask

  // Monitor: a valid channel must match its queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        if (ov8[k]) begin
          if (q8[k].size() == 0) begin
            chk("ov8_unexpected", 128'(ov8), 128'(0));
          end else begin
            chk("od8", 128'(od8[k*16 +: 16]), 128'(q8[k][0]));
            if (or8[k]) void'(q8[k].pop_front());
          end
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (ov5[k]) begin
          if (q5[k].size() == 0) begin
            chk("ov5_unexpected", 128'(ov5), 128'(0));
          end else begin
            chk("od5", 128'(od5[k*16 +: 16]), 128'(q5[k][0]));
            if (or5[k]) void'(q5[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_ov8", 128'(ov8), 128'(0));
    chk("rst_od8", od8, 128'(0));
    chk("rst_err8", 128'(err8), 128'(0));
    chk("rst_drop8", 128'(drop8), 128'(0));
    chk("rst_ov5", 128'(ov5), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    for (int s = 0; s < 8; s++) begin
      is8 = 3'(s);
      #1;
      chk("rdy_after_rst", 128'(in_ready8), 128'(1));
    end
    @(posedge clk); #1;

    // Sweep sel 0..7, all consumers ready
    for (int s = 0; s < 8; s++)
      send8(1, 3'(s), 0, 16'hA000 + 16'(s), 8'hFF, 1);
    send8(0, 0, 0, 0, 8'hFF, 0);

    // Backpressure on channel 3
    send8(1, 3, 0, 16'h1111, 8'hF7, 1);
    send8(1, 3, 0, 16'h2222, 8'hF7, 0);
    send8(1, 5, 0, 16'h5555, 8'hF7, 1);
    send8(1, 3, 0, 16'h2222, 8'hFF, 1);
    chk("bp_ch3_data", 128'(od8[63:48]), 128'(16'h2222));
    send8(0, 0, 0, 0, 8'hFF, 0);

    // Broadcast blocked by full channel 6, then released
    send8(1, 6, 0, 16'h6666, 8'hBF, 1);
    send8(1, 0, 1, 16'hBEEF, 8'hBF, 0);
    chk("bc_blocked_ov", 128'(ov8), 128'(8'h40));
    send8(1, 0, 1, 16'hBEEF, 8'hBF, 0);
    send8(1, 0, 1, 16'hBEEF, 8'hFF, 1);
    chk("bc_all_valid", 128'(ov8), 128'(8'hFF));
    chk("bc_all_data", od8, {8{16'hBEEF}});
    send8(0, 0, 0, 0, 8'hFF, 0);

    // Simultaneous drain and refill on channel 2
    send8(1, 2, 0, 16'hC001, 8'hFF, 1);
    send8(1, 2, 0, 16'hC002, 8'hFF, 1);
    chk("dr_ov2", 128'(ov8[2]), 128'(1));
    chk("dr_od2", 128'(od8[47:32]), 128'(16'hC002));
    send8(0, 0, 0, 0, 8'hFF, 0);
    for (int k = 0; k < 8; k++)
      chk("q8_drained", 128'(q8[k].size()), 128'(0));

    // Fill 0..3 with consumers stalled, then async reset mid-cycle
    for (int s = 0; s < 4; s++)
      send8(1, 3'(s), 0, 16'hD000 + 16'(s), 8'h00, 1);
    chk("pre_rst_ov8", 128'(ov8), 128'(8'h0F));
    reset = 1;
    #1;
    chk("mid_rst_ov8", 128'(ov8), 128'(0));
    chk("mid_rst_od8", od8, 128'(0));
    chk("mid_rst_err8", 128'(err8), 128'(0));
    chk("mid_rst_drop8", 128'(drop8), 128'(0));
    for (int k = 0; k < 8; k++) q8[k].delete();
    @(posedge clk); #1;
    reset = 0;
    or8 = 8'hFF;
    @(posedge clk); #1;

    // N=5: in-range item, then out-of-range drops
    send5(1, 4, 16'h4444, 1);
    for (int i = 0; i < 3; i++) send5(1, 6, 16'h0600, 1);
    chk("oor_ov5", 128'(ov5), 128'(0));
    chk("oor_err", 128'(err5), 128'(1));
    chk("oor_cnt3", 128'(drop5), 128'(3));
    for (int i = 0; i < 300; i++) send5(1, 3'(5 + (i % 3)), 16'h0, 1);
    chk("oor_sat", 128'(drop5), 128'(255));
    chk("oor_err_sat", 128'(err5), 128'(1));
    chk("oor_ov5_sat", 128'(ov5), 128'(0));
    clr5 = 1;
    send5(1, 7, 16'h0700, 1);
    clr5 = 0;
    chk("clr_cnt", 128'(drop5), 128'(0));
    chk("clr_err", 128'(err5), 128'(0));
    send5(0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      chk("q5_drained", 128'(q5[k].size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Parametrised, registered N-way demultiplexer: routes a WIDTH-bit payload from one valid/ready input stream to one of N output streams, or to all N in broadcast mode. Each output has a one-entry holding register, so a stalled channel blocks only traffic addressed to it. This is the sequential, handshaked successor to the combinational 1-bit DMUX8WAY. It sits between the instruction/data fabric and multi-consumer peripherals.

## Interface
- WIDTH, 16: payload width in bits (≥1)
- N, 8: output channel count (2..16, power of two not required)
- SEL_W, $clog2(N): select width (derived; not overridden)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input payload valid
- in_ready  out  1  input accepted this cycle when in_valid & in_ready
- in_data  in  WIDTH  payload
- in_sel  in  SEL_W  destination channel
- in_bcast  in  1  broadcast: deliver to all N channels, in_sel ignored
- out_valid  out  N  per-channel valid (bit k = channel k)
- out_ready  in  N  per-channel ready
- out_data  out  N*WIDTH  channel k at [k*WIDTH +: WIDTH]
- err  out  1  sticky: an out-of-range select was consumed
- drop_cnt  out  8  count of out-of-range transfers, saturating at 255
- clr_err  in  1  synchronous clear of err and drop_cnt

## Operation
- Channel k slot: full flag = out_valid[k], data register. It drains when out_valid[k] & out_ready[k].
- free[k] = ~out_valid[k] | out_ready[k]. Same-cycle drain and refill is allowed, giving full throughput.
- in_ready is combinational:
  - in_bcast=1: AND of free[0..N-1]
  - in_bcast=0, in_sel<N: free[in_sel]
  - in_sel≥N: 1 (always sink)
- On accept with a valid select: slot in_sel loads in_data and sets out_valid.
- On accept with broadcast: every slot loads in_data and sets out_valid. Delivery is all-or-nothing.
- On accept with in_sel≥N and in_bcast=0: the payload is dropped, err is set, and drop_cnt increments (saturates at 255). No slot changes.
- When N is a power of two, the out-of-range path is unreachable. It is still synthesised as constant-false.
- A slot that drains with no refill clears out_valid. out_data holds its last value; it is not cleared.
- clr_err=1 clears err and drop_cnt next edge. If a drop coincides with clr_err, the clear wins and err/drop_cnt end at 0.
- in_data, in_sel and in_bcast are don't-care while in_valid=0.

## Timing
- Reset (async assert, sync-to-clk deassert by the top level): out_valid=0, out_data=0, err=0, drop_cnt=0. After reset, in_ready=1 for any select.
- Latency: an accept on edge t gives out_valid[k]=1 with data after edge t, i.e. visible in cycle t+1.
- Throughput: one transfer per cycle per input, when the target consumer holds out_ready=1.
- Handshake rules:
  - Once out_valid[k]=1, out_data[k] stays stable until the handshake completes.
  - in_ready may depend on out_ready (combinational path out_ready→in_ready). Consumers must not make out_ready depend on in_ready.
- Reset asserted mid-transfer discards all slot contents immediately. Pending payloads are lost by design.
- A channel never holds more than one item, so there is no overflow condition.

## Structure
- Package dmux_pkg holds:
  - the drop_cnt width constant (8) and its saturation value (255)
  - the slot-index function idx_valid(sel, N)
- Sub-module dmux_slot: one-entry register with full flag, load and drain. It is instantiated N times by a generate loop.
- The top level contains only the in_ready decode, the load-enable vector and the error counter.

## Test plan
- Reset mid-run: fill channels 0..3, assert reset → out_valid=8'h00, out_data all 0, err=0, drop_cnt=0 immediately (asynchronously).
- Sweep: N=8, WIDTH=16, all out_ready=1; send sel 0..7 with data 16'hA000+sel → each appears once on channel sel one cycle later; other out_valid bits stay 0; in_ready=1 throughout.
- Backpressure: out_ready[3]=0; send two items to sel=3 (16'h1111, 16'h2222) → the first is held stable on channel 3 and in_ready=0 for sel=3, while items to sel=5 still pass. Raising out_ready[3] delivers 16'h2222 next cycle.
- Broadcast: in_bcast=1, data 16'hBEEF, out_ready[6]=0 with channel 6 full → in_ready=0 and no slot loads. Release channel 6 → all 8 channels present 16'hBEEF in the same cycle.
- Out-of-range: N=5, send sel=6 three times → in_ready=1, no out_valid change, err=1, drop_cnt=3. Send 300 drops → drop_cnt=255. clr_err together with a drop → drop_cnt=0, err=0.
- Simultaneous drain/refill: channel 2 full with out_ready[2]=1 and a new item to sel=2 in the same cycle → in_ready=1, the old item is consumed, the new item is visible the next cycle, with no bubble.
